// File: rtl/sync_trigger_event_ctrl.sv
// sync_trigger_event_ctrl
//   Turns an already-synchronized trigger bit (camera trigger, frame-valid)
//   into debounced level/edge information and a req/ack event stream for
//   the image-processing control core.
//
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous active-high reset
//   sync_in      synchronized input bit
//   enable       1 = rising events raise requests and are counted
//   clear        synchronous clear of event_count and overrun
//   event_ack    core acknowledge of the pending request
//   level_out    debounced level
//   rise_pulse   one-cycle pulse when level_out goes 0->1
//   fall_pulse   one-cycle pulse when level_out goes 1->0
//   event_req    pending event request
//   event_count  number of qualified rising events (wraps)
//   overrun      sticky: qualified rise while a request was still pending
module sync_trigger_event_ctrl #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 sync_in,
    input  logic                 enable,
    input  logic                 clear,
    input  logic                 event_ack,
    output logic                 level_out,
    output logic                 rise_pulse,
    output logic                 fall_pulse,
    output logic                 event_req,
    output logic [CNT_WIDTH-1:0] event_count,
    output logic                 overrun
);

    localparam int            DW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(STABLE_CYCLES - 1);

    typedef enum logic {IDLE, REQ} state_t;

    state_t        state;
    logic [DW-1:0] db_cnt;
    // Registered alongside rise_pulse: high in exactly the cycle rise_pulse
    // is high, if enable was sampled high on the edge that set the pulse.
    logic          qual_rise;
    logic          ov_set;

    // A qualified rise landing on a pending, un-acked request is an overrun.
    assign ov_set = qual_rise && (state == REQ) && !event_ack;

    // Debounce and edge pulses
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            db_cnt     <= '0;
            level_out  <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            qual_rise  <= 1'b0;
        end else begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            qual_rise  <= 1'b0;
            if (sync_in == level_out) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                level_out  <= ~level_out;
                db_cnt     <= '0;
                rise_pulse <= ~level_out;
                fall_pulse <= level_out;
                qual_rise  <= ~level_out & enable;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Event handshake FSM, counter and overrun
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            event_req   <= 1'b0;
            event_count <= '0;
            overrun     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (qual_rise) begin
                        state     <= REQ;
                        event_req <= 1'b1;
                    end
                end
                REQ: begin
                    // A rise alongside an ack is a back-to-back event, so the
                    // request simply stays up; without an ack it is dropped
                    // (only flagged via overrun).
                    if (!qual_rise && event_ack) begin
                        state     <= IDLE;
                        event_req <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    event_req <= 1'b0;
                end
            endcase

            if (clear)
                event_count <= qual_rise ? CNT_WIDTH'(1) : '0;
            else if (qual_rise)
                event_count <= event_count + CNT_WIDTH'(1);

            if (clear)
                overrun <= ov_set;
            else if (ov_set)
                overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sync_trigger_event_ctrl.sv
module tb_sync_trigger_event_ctrl;

    localparam int SC = 4;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          sync_in = 1'b0, enable = 1'b1, clear = 1'b0, event_ack = 1'b0;
    logic          level_out, rise_pulse, fall_pulse, event_req, overrun;
    logic [CW-1:0] event_count;

    int checks = 0;
    int errors = 0;

    sync_trigger_event_ctrl #(.STABLE_CYCLES(SC), .CNT_WIDTH(CW)) dut (
        .clock(clock), .reset(reset), .sync_in(sync_in), .enable(enable),
        .clear(clear), .event_ack(event_ack), .level_out(level_out),
        .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .event_req(event_req),
        .event_count(event_count), .overrun(overrun)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the level flips once the last SC samples all
    // disagree with it; events are bookkept as plain integers.
    bit hist[$];
    bit m_level, m_rise, m_fall, m_qual, m_req, m_ov;
    int m_cnt;

    initial begin
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                hist.delete();
                m_level = 0; m_rise = 0; m_fall = 0; m_qual = 0;
                m_req = 0; m_ov = 0; m_cnt = 0;
            end else begin
                bit ovc, all_diff;
                ovc = m_qual && m_req && !event_ack;
                if (clear) m_cnt = m_qual ? 1 : 0;
                else if (m_qual) m_cnt = (m_cnt + 1) % (1 << CW);
                m_ov = clear ? ovc : (m_ov || ovc);
                if (m_qual) m_req = 1;
                else if (event_ack) m_req = 0;

                hist.push_back(sync_in);
                if (hist.size() > SC) void'(hist.pop_front());
                all_diff = (hist.size() == SC);
                foreach (hist[i]) if (hist[i] == m_level) all_diff = 0;
                m_rise = all_diff && !m_level;
                m_fall = all_diff && m_level;
                m_qual = m_rise && enable;
                if (all_diff) begin
                    m_level = !m_level;
                    hist.delete();
                end
            end
        end
    end

    // Compare every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clock);
            chk("level_out", level_out, m_level);
            chk("rise_pulse", rise_pulse, m_rise);
            chk("fall_pulse", fall_pulse, m_fall);
            chk("event_req", event_req, m_req);
            chk("event_count", event_count, m_cnt);
            chk("overrun", overrun, m_ov);
        end
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic rise_evt();   // from level 0: full rise, then request visible
        sync_in = 1; edges(SC + 1);
    endtask

    task automatic fall_evt();
        sync_in = 0; edges(SC);
    endtask

    initial begin
        #1;
        chk("reset_level", level_out, 0);
        chk("reset_req", event_req, 0);
        chk("reset_cnt", event_count, 0);
        edges(2);
        reset = 0;
        edges(1);

        // Basic rise: level and pulse on the SC-th edge, request one later
        sync_in = 1; edges(SC);
        chk("rise_level", level_out, 1);
        chk("rise_pulse_on", rise_pulse, 1);
        chk("rise_req_not_yet", event_req, 0);
        edges(1);
        chk("rise_pulse_off", rise_pulse, 0);
        chk("rise_req", event_req, 1);
        chk("rise_cnt", event_count, 1);
        event_ack = 1; edges(1); event_ack = 0;
        chk("ack_drops_req", event_req, 0);
        fall_evt();
        chk("fall_level", level_out, 0);

        // Glitch of SC-1 cycles
        sync_in = 1; edges(SC - 1); sync_in = 0; edges(SC);
        chk("glitch_level", level_out, 0);
        chk("glitch_cnt", event_count, 1);

        // Held request, then overrun
        rise_evt(); edges(10);
        chk("held_req", event_req, 1);
        chk("held_cnt", event_count, 2);
        fall_evt(); rise_evt();
        chk("ovr_flag", overrun, 1);
        chk("ovr_cnt", event_count, 3);
        event_ack = 1; edges(1); event_ack = 0;
        chk("ovr_ack", event_req, 0);
        clear = 1; edges(1); clear = 0;
        chk("clear_cnt", event_count, 0);
        chk("clear_ovr", overrun, 0);

        // Rise coinciding with ack and clear
        rise_evt(); fall_evt();
        sync_in = 1; edges(SC);
        event_ack = 1; clear = 1; edges(1); event_ack = 0; clear = 0;
        chk("sim_req", event_req, 1);
        chk("sim_ovr", overrun, 0);
        chk("sim_cnt", event_count, 1);

        // Disabled rise
        event_ack = 1; edges(1); event_ack = 0;
        fall_evt(); enable = 0; sync_in = 1; edges(SC);
        chk("dis_pulse", rise_pulse, 1);
        edges(1);
        chk("dis_cnt", event_count, 1);
        chk("dis_req", event_req, 0);
        enable = 1;

        // Wrap: 16 more qualified rises on a 4-bit counter
        event_ack = 1;
        for (int i = 0; i < 16; i++) begin fall_evt(); rise_evt(); end
        chk("wrap_cnt", event_count, 1);
        event_ack = 0;

        // Reset mid-request with count 5
        clear = 1; edges(1); clear = 0;
        for (int i = 0; i < 5; i++) begin fall_evt(); rise_evt(); end
        chk("pre_rst_req", event_req, 1);
        chk("pre_rst_cnt", event_count, 5);
        #2 reset = 1; #1;
        chk("async_rst_req", event_req, 0);
        chk("async_rst_cnt", event_count, 0);
        chk("async_rst_level", level_out, 0);
        chk("async_rst_ovr", overrun, 0);
        edges(2);
        reset = 0;

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(3) == 0) sync_in = ~sync_in;
            enable    = ($urandom_range(99) < 85);
            clear     = ($urandom_range(99) < 5);
            event_ack = ($urandom_range(99) < 30);
            edges(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sync_trigger_event_ctrl.md
Name: sync_trigger_event_ctrl

Overview:
- Consumes a single bit produced by the two-flop bit synchronizer, e.g. an external camera trigger or frame-valid line.
- Debounces the bit, generates one-cycle rise/fall pulses, and counts qualified rising events.
- Presents each event to the image-processing control core over a req/ack handshake.
- Sticky overrun flag when a new event arrives before the previous one is acknowledged.

Parameters:
- STABLE_CYCLES, 4, consecutive clock edges the input must differ from the filtered level before the level changes; legal range 1..255.
- CNT_WIDTH, 16, width of the event counter.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- sync_in  input  1  already-synchronized bit from the synchronizer stage.
- enable  input  1  1 = rising events generate requests and are counted; 0 = events suppressed.
- clear  input  1  synchronous clear of event_count and overrun.
- event_ack  input  1  core acknowledge of the current request.
- level_out  output  1  debounced level.
- rise_pulse  output  1  one-cycle pulse on filtered 0->1.
- fall_pulse  output  1  one-cycle pulse on filtered 1->0.
- event_req  output  1  pending event request to the core.
- event_count  output  CNT_WIDTH  number of qualified rising events.
- overrun  output  1  sticky: a rise occurred while a request was pending.

Behaviour:
- Reset: asynchronous, active-high, clears every register regardless of clock.
  - Outputs on reset: level_out=0, rise_pulse=0, fall_pulse=0, event_req=0, event_count=0, overrun=0.
  - Internal state on reset: FSM=IDLE, debounce counter=0.
  - Reset asserted mid-request drops event_req immediately.
  - First edge after deassert behaves as normal operation.
- Debounce counter: width clog2(STABLE_CYCLES+1).
  - Each edge with sync_in==level_out: counter <= 0.
  - Each edge with sync_in!=level_out and counter==STABLE_CYCLES-1: level_out toggles; counter <= 0.
  - Otherwise with sync_in!=level_out: counter increments.
  - Net effect: level_out changes on the STABLE_CYCLES-th consecutive edge seeing the differing input. STABLE_CYCLES=1 gives a single register delay.
  - A glitch shorter than STABLE_CYCLES edges never changes level_out.
- Edge pulses: rise_pulse/fall_pulse are registered and assert in the same cycle level_out takes its new value, for exactly one cycle. They are independent of enable.
- A qualified rise is rise_pulse==1 while enable==1, with enable sampled on the same edge that sets rise_pulse.
- Event FSM, two states:
  - IDLE: event_req=0. A qualified rise moves to REQ; event_req=1 from the next cycle. event_ack in IDLE is ignored.
  - REQ: event_req=1. event_ack sampled high with no qualified rise: go to IDLE, event_req=0 next cycle.
  - REQ, event_ack high and a qualified rise on the same edge: stay in REQ, event_req stays 1 (back-to-back event), no overrun.
  - REQ, qualified rise without ack: stay in REQ, overrun <= 1, nothing queued.
- Counter:
  - event_count increments by 1 on every qualified rise, including overrun rises.
  - Wraps from 2^CNT_WIDTH-1 to 0 with no flag.
  - event_count is registered; the increment is visible the cycle after rise_pulse.
- Clear:
  - clear=1 sets event_count<=0 and overrun<=0.
  - If clear and a qualified rise occur on the same edge, event_count<=1.
  - If clear and an overrun condition occur on the same edge, overrun<=1.
  - clear does not affect FSM, level_out or the pulses.
- enable deasserted while in REQ: the pending request still completes normally via event_ack.
- sync_in held high through reset release: level_out rises after STABLE_CYCLES edges and produces a normal rise event.

Test Plan:
- STABLE_CYCLES=4; reset, then sync_in 0->1 held -> level_out=1 and rise_pulse=1 for one cycle on the 4th edge after the change; event_req=1 the next cycle; event_count=1.
- Glitch: sync_in high for 3 cycles, then low -> level_out stays 0, no pulses, event_count=0.
- Handshake: after a rise, hold event_ack=0 for 10 cycles -> event_req stays 1; pulse ack for 1 cycle -> event_req=0 the next cycle. A second rise before the ack -> overrun=1, event_count=2.
- Simultaneous: qualified rise on the same edge as event_ack -> event_req remains 1, overrun=0. clear on the same edge as a rise -> event_count=1, overrun=0.
- Wrap and enable: CNT_WIDTH=4, 16 qualified rises -> event_count=0. enable=0 rise -> rise_pulse asserted, event_count and event_req unchanged.
- Reset mid-operation: assert reset while event_req=1 and counter=5 -> all outputs 0 immediately, without a clock edge.
